// File: rtl/uart_tx_port.sv
// uart_tx_port: CPU IO-write byte port with FIFO, serialised as 8N1 on txd, LSB first.
// Optional even parity bit when UART_TX_PARITY_EN is defined (frame grows to 11 bits).
// Ports: clk, reset_n (async, active low), databus/io_wr_n (CPU write),
//   tx_ready (FIFO not full), tx_busy (frame in progress), txd (idle high),
//   overrun (sticky dropped write), fifo_count (bytes queued, excl. frame in flight).
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [7:0]                    databus,
  input  logic                          io_wr_n,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic                          txd,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [FW-1:0] FULL     = FW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd3;
`endif
  localparam logic [2:0] S_STOP  = 3'd4;

  logic          wr_q;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [FW-1:0] count;
  logic [2:0]    state;
  logic [CW-1:0] baud;
  logic [2:0]    bitn;
  logic [7:0]    shift;
  logic          ovr;
`ifdef UART_TX_PARITY_EN
  logic          par_q;
`endif

  logic wr_edge;
  logic nonempty;
  logic bit_end;
  logic pop;
  logic push;

  // Falling edge of the strobe; wr_q resets high so a
  // write on the first edge after reset still counts.
  assign wr_edge  = ~io_wr_n & wr_q;
  assign nonempty = (count != '0);
  assign bit_end  = (baud == '0);
  // Pop from IDLE at once, or at the end of STOP so the
  // next start bit follows the stop bit with no gap.
  assign pop  = nonempty &
                ((state == S_IDLE) |
                 ((state == S_STOP) & bit_end));
  // A full FIFO still takes a byte if the head leaves
  // on the same edge.
  assign push = wr_edge & ((count != FULL) | pop);

  assign tx_ready   = (count != FULL);
  assign tx_busy    = (state != S_IDLE);
  assign overrun    = ovr;
  assign fifo_count = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q <= 1'b1;
      ovr  <= 1'b0;
    end else begin
      wr_q <= io_wr_n;
      if (wr_edge && !push)
        ovr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= databus;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + 1'b1;
      if (pop)
        rptr <= rptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      baud  <= '0;
      bitn  <= '0;
      shift <= '0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else if (pop) begin
      state <= S_START;
      baud  <= BAUD_MAX;
      shift <= mem[rptr];
`ifdef UART_TX_PARITY_EN
      par_q <= ^mem[rptr];
`endif
    end else if (state != S_IDLE) begin
      if (bit_end) begin
        baud <= BAUD_MAX;
        unique case (state)
          S_START: begin
            state <= S_DATA;
            bitn  <= '0;
          end
          S_DATA: begin
            shift <= {1'b0, shift[7:1]};
            bitn  <= bitn + 1'b1;
            if (bitn == 3'd7)
`ifdef UART_TX_PARITY_EN
              state <= S_PAR;
`else
              state <= S_STOP;
`endif
          end
`ifdef UART_TX_PARITY_EN
          S_PAR:   state <= S_STOP;
`endif
          default: state <= S_IDLE;
        endcase
      end else begin
        baud <= baud - 1'b1;
      end
    end
  end

  always_comb begin
    txd = 1'b1;
    unique case (1'b1)
      (state == S_START): txd = 1'b0;
      (state == S_DATA):  txd = shift[0];
`ifdef UART_TX_PARITY_EN
      (state == S_PAR):   txd = par_q;
`endif
      default:            txd = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: randomized and directed checks of uart_tx_port
// against a frame-timeline reference model (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_uart_tx_port;

  localparam int CPB = 4;
  localparam int D   = 4;
  localparam int FW  = 3;
`ifdef UART_TX_PARITY_EN
  localparam int NB  = 11;
`else
  localparam int NB  = 10;
`endif
  localparam int FL  = NB * CPB;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    databus = 8'h00;
  logic          io_wr_n = 1'b1;
  logic          tx_ready;
  logic          tx_busy;
  logic          txd;
  logic          overrun;
  logic [FW-1:0] fifo_count;

  int tests = 0;
  int fails = 0;

  uart_tx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .databus(databus),
    .io_wr_n(io_wr_n), .tx_ready(tx_ready), .tx_busy(tx_busy),
    .txd(txd), .overrun(overrun), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  logic [6:0] obs;
  assign obs = {txd, tx_busy, tx_ready, overrun, fifo_count};

  // Reference model: a queue of waiting bytes and the start
  // edge of the frame on the line; the line level is derived
  // from the elapsed time inside that frame.
  logic [7:0] q[$];
  int         m_cyc = 0;
  int         m_start = -1000;
  logic [7:0] m_byte = 8'h00;
  logic       m_prev = 1'b1;
  logic       m_ovr = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_cyc   <= 0;
      m_start <= -1000;
      m_prev  <= 1'b1;
      m_ovr   <= 1'b0;
    end else begin
      m_cyc  <= m_cyc + 1;
      m_prev <= io_wr_n;
      if (q.size() != 0 && (m_cyc - m_start) >= FL) begin
        m_byte  <= q.pop_front();
        m_start <= m_cyc;
      end
      if (!io_wr_n && m_prev) begin
        if (q.size() < D)
          q.push_back(databus);
        else
          m_ovr <= 1'b1;
      end
    end
  end

  function automatic logic [6:0] m_vec();
    int   k;
    int   i;
    logic b;
    logic busy;
    k = m_cyc - 1 - m_start;
    busy = (k >= 0 && k < FL);
    b = 1'b1;
    if (busy) begin
      i = k / CPB;
      if (i == 0)
        b = 1'b0;
      else if (i <= 8)
        b = m_byte[i-1];
      else if (NB == 11 && i == 9)
        b = ^m_byte;
    end
    return {b, busy, (q.size() != D), m_ovr, FW'(q.size())};
  endfunction

  logic line[$];

  function automatic void decode(input logic ln[$],
                                 output logic [7:0] got[$]);
    int i;
    logic [7:0] b;
    got = {};
    i = 0;
    while (i < ln.size()) begin
      if (ln[i] == 1'b0 && i + FL <= ln.size()) begin
        for (int k = 0; k < 8; k++)
          b[k] = ln[i + CPB * (k + 1) + CPB / 2];
        got.push_back(b);
        i = i + FL;
      end else begin
        i = i + 1;
      end
    end
  endfunction

  task automatic put(input logic wn, input logic [7:0] d);
    io_wr_n = wn;
    databus = d;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    put(1'b1, 8'h00);
    repeat (2) @(negedge clk);
    tests++;
    if (txd !== 1'b1) begin
      fails++; $display("FAIL reset_txd got %b exp 1", txd);
    end
    tests++;
    if (tx_busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy got %b exp 0", tx_busy);
    end
    tests++;
    if (tx_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready got %b exp 1", tx_ready);
    end
    tests++;
    if (overrun !== 1'b0) begin
      fails++; $display("FAIL reset_ovr got %b exp 0", overrun);
    end
    tests++;
    if (fifo_count !== 3'd0) begin
      fails++; $display("FAIL reset_count got %0d exp 0", fifo_count);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    int busy_n;
    logic [7:0] got[$];
    busy_n = 0;
    line = {};
    put(1'b0, 8'h55);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin
        fails++;
        $display("FAIL single c=%0d got %b exp %b", c, obs, m_vec());
      end
      if (c == 0) begin
        tests++;
        if (txd !== 1'b1 || fifo_count !== 3'd1) begin
          fails++;
          $display("FAIL single_lat got txd=%b cnt=%0d exp 1/1", txd, fifo_count);
        end
      end
      if (c == 1) begin
        tests++;
        if (txd !== 1'b0) begin
          fails++; $display("FAIL single_start got %b exp 0", txd);
        end
      end
      if (tx_busy) busy_n++;
      line.push_back(txd);
      put(1'b1, 8'h00);
    end
    tests++;
    if (busy_n != FL) begin
      fails++; $display("FAIL single_busy got %0d exp %0d", busy_n, FL);
    end
    decode(line, got);
    tests++;
    if (got.size() != 1 || got[0] !== 8'h55) begin
      fails++;
      $display("FAIL single_line got n=%0d b0=%h exp 55", got.size(),
               got.size() ? got[0] : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    int busy_n;
    int first;
    int last;
    first = -1;
    last = -1;
    busy_n = 0;
    for (int c = 0; c < 100; c++) begin
      if (c == 0) put(1'b0, 8'h41);
      else if (c == 2) put(1'b0, 8'h42);
      else put(1'b1, 8'h00);
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin
        fails++;
        $display("FAIL b2b c=%0d got %b exp %b", c, obs, m_vec());
      end
      if (tx_busy) begin
        busy_n++;
        if (first < 0) first = c;
        last = c;
      end
    end
    tests++;
    if (busy_n != 2 * FL || last - first + 1 != 2 * FL) begin
      fails++;
      $display("FAIL b2b_gap got busy=%0d span=%0d exp %0d",
               busy_n, last - first + 1, 2 * FL);
    end
  endtask

  task automatic test_burst();
    logic [7:0] wr[6];
    logic [7:0] got[$];
    line = {};
    for (int i = 0; i < 6; i++) wr[i] = 8'($urandom_range(0, 255));
    for (int c = 0; c < 5 * FL + 30; c++) begin
      if (c < 12 && c % 2 == 0) put(1'b0, wr[c/2]);
      else put(1'b1, 8'h00);
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin
        fails++;
        $display("FAIL burst c=%0d got %b exp %b", c, obs, m_vec());
      end
      if (c == 11) begin
        tests++;
        if (tx_ready !== 1'b0 || overrun !== 1'b1 || fifo_count !== 3'd4) begin
          fails++;
          $display("FAIL burst_full got rdy=%b ovr=%b cnt=%0d exp 0/1/4",
                   tx_ready, overrun, fifo_count);
        end
      end
      line.push_back(txd);
    end
    decode(line, got);
    tests++;
    if (got.size() != 5) begin
      fails++; $display("FAIL burst_n got %0d exp 5", got.size());
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      tests++;
      if (got[i] !== wr[i]) begin
        fails++; $display("FAIL burst_b%0d got %h exp %h", i, got[i], wr[i]);
      end
    end
  endtask

  task automatic test_hold();
    int maxc;
    logic [7:0] got[$];
    maxc = 0;
    line = {};
    for (int c = 0; c < 60; c++) begin
      if (c < 10) put(1'b0, 8'h33);
      else put(1'b1, 8'h00);
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin
        fails++;
        $display("FAIL hold c=%0d got %b exp %b", c, obs, m_vec());
      end
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      line.push_back(txd);
    end
    tests++;
    if (maxc != 1) begin
      fails++; $display("FAIL hold_max got %0d exp 1", maxc);
    end
    decode(line, got);
    tests++;
    if (got.size() != 1 || got[0] !== 8'h33) begin
      fails++;
      $display("FAIL hold_line got n=%0d exp one 33", got.size());
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    logic [7:0] got[$];
    ok = 1'b0;
    put(1'b0, 8'hA5);
    for (int i = 0; i < 6 && !ok; i++) begin
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin
        fails++;
        $display("FAIL rmid_wait got %b exp %b", obs, m_vec());
      end
      if (tx_busy) ok = 1'b1;
      put(1'b1, 8'h00);
    end
    tests++;
    if (!ok) begin
      fails++; $display("FAIL rmid_timeout got busy=0 exp 1");
    end
    repeat (14) @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests++;
    if (txd !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0) begin
      fails++;
      $display("FAIL rmid_abort got txd=%b busy=%b cnt=%0d exp 1/0/0",
               txd, tx_busy, fifo_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    line = {};
    put(1'b0, 8'h01);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin
        fails++;
        $display("FAIL rmid c=%0d got %b exp %b", c, obs, m_vec());
      end
      line.push_back(txd);
      put(1'b1, 8'h00);
    end
    decode(line, got);
    tests++;
    if (got.size() != 1 || got[0] !== 8'h01) begin
      fails++;
      $display("FAIL rmid_line got n=%0d exp one 01", got.size());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 700; c++) begin
      if (c < 400)
        put(($urandom_range(0, 9) != 0), 8'($urandom_range(0, 255)));
      else
        put(1'b1, 8'h00);
      @(negedge clk);
      tests++;
      if (obs !== m_vec()) begin
        fails++;
        $display("FAIL rand c=%0d got %b exp %b", c, obs, m_vec());
      end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] bv[2];
    logic       pv[2];
    int         busy_n;
    int         s;
    bv[0] = 8'h07; pv[0] = 1'b1;
    bv[1] = 8'h03; pv[1] = 1'b0;
    for (int t = 0; t < 2; t++) begin
      line = {};
      busy_n = 0;
      put(1'b0, bv[t]);
      for (int c = 0; c < 55; c++) begin
        @(negedge clk);
        tests++;
        if (obs !== m_vec()) begin
          fails++;
          $display("FAIL par c=%0d got %b exp %b", c, obs, m_vec());
        end
        if (tx_busy) busy_n++;
        line.push_back(txd);
        put(1'b1, 8'h00);
      end
      s = -1;
      for (int i = 0; i < line.size() && s < 0; i++)
        if (line[i] == 1'b0) s = i;
      tests++;
      if (s < 0 || line[s + 9 * CPB + CPB / 2] !== pv[t]) begin
        fails++; $display("FAIL par_bit%0d got bad exp %b", t, pv[t]);
      end
      tests++;
      if (busy_n != 11 * CPB) begin
        fails++; $display("FAIL par_len got %0d exp %0d", busy_n, 11 * CPB);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_burst();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
